riscv_rvalid_stall: RTL and testbench



---
 rtl/riscv_stall_pkg.sv | 18 +
 rtl/riscv_rvalid_stall_if.sv | 30 +++
 rtl/riscv_stall_lfsr.sv | 17 +
 rtl/riscv_rvalid_stall.sv | 124 ++++++++++++
 tb/tb_riscv_rvalid_stall.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_stall_pkg.sv
// Shared definitions for the OBI stall blocks (grant side and rvalid side).
package riscv_stall_pkg;

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_FIXED  = 2'd1,
    STALL_RANDOM = 2'd2
  } stall_mode_e;

  localparam logic [31:0] LFSR_SEED = 32'h1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/riscv_rvalid_stall_if.sv
// Response-phase bundle between memory model, rvalid staller and core,
// plus the stall configuration knobs and status flags.
interface riscv_rvalid_stall_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  core_rvalid_o;
  logic [DATA_WIDTH-1:0] core_rdata_o;
  logic                  en_stall_i;
  logic [31:0]           stall_mode_i;
  logic [31:0]           max_stall_i;
  logic [31:0]           rvalid_stall_i;
  logic                  full_o;
  logic                  overflow_o;

  // Stall block side.
  modport slave (
    input  mem_rvalid_i, mem_rdata_i, en_stall_i, stall_mode_i,
           max_stall_i, rvalid_stall_i,
    output core_rvalid_o, core_rdata_o, full_o, overflow_o
  );

  // Memory model / bench side.
  modport master (
    output mem_rvalid_i, mem_rdata_i, en_stall_i, stall_mode_i,
           max_stall_i, rvalid_stall_i,
    input  core_rvalid_o, core_rdata_o, full_o, overflow_o
  );
endinterface

// File: rtl/riscv_stall_lfsr.sv
// 32-bit Galois LFSR, seeded on reset, stepping only when enabled.
module riscv_stall_lfsr
  import riscv_stall_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] state
);

  // Advance one step per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= LFSR_SEED;
    else if (en) state <= lfsr_step(state);
  end

endmodule

// File: rtl/riscv_rvalid_stall.sv
// OBI response-phase staller: every memory response is queued in order and
// released to the core after its own programmable delay.
// Optional feature macro: RVALID_STALL_LFSR_EN (LFSR-driven RANDOM mode;
// without it RANDOM behaves like FIXED with delay max_stall_i).
module riscv_rvalid_stall
  import riscv_stall_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  riscv_rvalid_stall_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [CNT_WIDTH-1:0]  dly_q  [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr, rd_nxt;
  logic [PW:0]           count;
  logic [CNT_WIDTH-1:0]  head_cnt;

  logic [31:0]           rand_dly, d_raw;
  logic [CNT_WIDTH-1:0]  d_in, head_dly;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  push, push_ok, pop, empty, head_vld;

`ifdef RVALID_STALL_LFSR_EN
  logic [31:0] lfsr;

  riscv_stall_lfsr u_lfsr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (bus.mem_rvalid_i),
    .state (lfsr)
  );

  // max_stall_i of all ones would overflow max+1; the full LFSR range is the answer there.
  always_comb begin
    rand_dly = lfsr;
    if (bus.max_stall_i != 32'hFFFF_FFFF) rand_dly = lfsr % (bus.max_stall_i + 32'd1);
  end
`else
  // No LFSR: RANDOM collapses to a fixed worst-case delay.
  always_comb rand_dly = bus.max_stall_i;
`endif

  // Delay chosen for the response arriving this cycle, saturated to the counter width.
  always_comb begin
    d_raw = 32'd0;
    if (bus.en_stall_i) begin
      if (bus.stall_mode_i == 32'(STALL_FIXED))       d_raw = bus.rvalid_stall_i;
      else if (bus.stall_mode_i == 32'(STALL_RANDOM)) d_raw = rand_dly;
    end
    d_in = (d_raw > 32'(CNT_SAT)) ? CNT_SAT : d_raw[CNT_WIDTH-1:0];
  end

  // An arrival into an empty queue is head in its own cycle, which gives the
  // one-cycle minimum latency without a separate bypass path.
  always_comb begin
    push      = bus.mem_rvalid_i;
    empty     = (count == '0);
    head_vld  = !empty || push;
    head_dly  = empty ? d_in : head_cnt;
    head_data = empty ? bus.mem_rdata_i : data_q[rd_ptr];
    pop       = head_vld && (head_dly == '0);
    push_ok   = push && ((count != (PW+1)'(DEPTH)) || pop);
    rd_nxt    = rd_ptr + PW'(1);
  end

  // Entry storage; no reset needed, validity lives in count.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      data_q[wr_ptr] <= bus.mem_rdata_i;
      dly_q[wr_ptr]  <= d_in;
    end
  end

  // Pointers, occupancy, head countdown and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      head_cnt       <= '0;
      bus.overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_nxt;
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
      // The next head starts counting in the cycle right after the pop.
      if (pop) begin
        if (count >= (PW+1)'(2))                head_cnt <= dly_q[rd_nxt];
        else if (count == (PW+1)'(1) && push_ok) head_cnt <= d_in;
      end else if (empty) begin
        if (push) head_cnt <= d_in - CNT_WIDTH'(1);
      end else begin
        head_cnt <= head_cnt - CNT_WIDTH'(1);
      end
      if (push && !push_ok) bus.overflow_o <= 1'b1;
    end
  end

  // Registered single-cycle response to the core; data forced to zero when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.core_rvalid_o <= 1'b0;
      bus.core_rdata_o  <= '0;
    end else begin
      bus.core_rvalid_o <= pop;
      bus.core_rdata_o  <= pop ? head_data : '0;
    end
  end

  assign bus.full_o = (count == (PW+1)'(DEPTH));

endmodule

// File: tb/tb_riscv_rvalid_stall.sv
// Directed bench for riscv_rvalid_stall: modes, timing, overflow,
// saturation, mid-flight reset and RANDOM delay spread.
module tb_riscv_rvalid_stall;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int          c;
    int          r;
    logic [31:0] d;
    bit          rnd;
  } exp_t;

  exp_t        exp_q[$];
  bit          hits[8];
  logic [31:0] lfsr_m = 32'h1;

  riscv_rvalid_stall_if #(.DATA_WIDTH(32)) bus ();

  riscv_rvalid_stall #(.DEPTH(4), .DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one response for one cycle; keep=0 means the bench expects it dropped.
  task automatic send(input logic [31:0] d, input int r, input bit keep, input bit rnd);
    if (keep) exp_q.push_back('{c: cyc, r: r, d: d, rnd: rnd});
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = d;
    lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 32'h8020_0003 : 32'h0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic set_mode(input bit en, input int mode, input int fixed, input int mx);
    bus.en_stall_i     = en;
    bus.stall_mode_i   = mode;
    bus.rvalid_stall_i = fixed;
    bus.max_stall_i    = mx;
  endtask

  // Output monitor: every core response must match the head of the expected queue.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.core_rvalid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          int   dobs;
          e = exp_q.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(e.r));
          chk("rdata", 64'(bus.core_rdata_o), 64'(e.d));
          if (e.rnd) begin
            dobs = cyc - e.c - 1;
            chk("rnd_range", 64'(dobs >= 0 && dobs <= 7), 64'd1);
            if (dobs >= 0 && dobs <= 7) hits[dobs] = 1'b1;
          end
        end
      end else begin
        chk("rdata_idle", 64'(bus.core_rdata_o), 64'd0);
      end
    end
  end

  initial begin
    int c0;
    int nhit;
    int dly;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    set_mode(1'b0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    chk("rst_rvalid", 64'(bus.core_rvalid_o), 64'd0);
    chk("rst_rdata", 64'(bus.core_rdata_o), 64'd0);
    chk("rst_full", 64'(bus.full_o), 64'd0);
    chk("rst_ovf", 64'(bus.overflow_o), 64'd0);
    #1 rst_n = 1'b1;
    lfsr_m = 32'h1;
    tick();
    tick();

    // NONE: back-to-back, one-cycle latency, no bubbles
    set_mode(1'b1, 0, 9, 9);
    c0 = cyc;
    send(32'hA, c0 + 1, 1, 0); chk("none_full", 64'(bus.full_o), 64'd0);
    send(32'hB, c0 + 2, 1, 0); chk("none_full", 64'(bus.full_o), 64'd0);
    send(32'hC, c0 + 3, 1, 0); chk("none_full", 64'(bus.full_o), 64'd0);
    wait_empty(20);

    // Stall disabled overrides FIXED
    set_mode(1'b0, 1, 3, 0);
    c0 = cyc;
    send(32'h11, c0 + 1, 1, 0);
    wait_empty(20);

    // FIXED 3: c -> c+4, c+1 -> c+8
    set_mode(1'b1, 1, 3, 0);
    c0 = cyc;
    send(32'h20, c0 + 4, 1, 0);
    send(32'h21, c0 + 8, 1, 0);
    wait_empty(30);

    // Saturation: 1000 clamps to 255
    set_mode(1'b1, 1, 1000, 0);
    c0 = cyc;
    send(32'h5A7, c0 + 256, 1, 0);
    wait_empty(300);

    // Overflow with DEPTH=4 and delay 50
    set_mode(1'b1, 1, 50, 0);
    c0 = cyc;
    send(32'h1, c0 + 51, 1, 0);
    send(32'h2, c0 + 102, 1, 0);
    send(32'h3, c0 + 153, 1, 0);
    chk("ovf_full_3", 64'(bus.full_o), 64'd0);
    send(32'h4, c0 + 204, 1, 0);
    chk("ovf_full_4", 64'(bus.full_o), 64'd1);
    chk("ovf_pre", 64'(bus.overflow_o), 64'd0);
    send(32'h5, 0, 0, 0);
    chk("ovf_set", 64'(bus.overflow_o), 64'd1);
    chk("ovf_full_5", 64'(bus.full_o), 64'd1);
    wait_empty(300);
    chk("ovf_sticky", 64'(bus.overflow_o), 64'd1);
    chk("ovf_full_end", 64'(bus.full_o), 64'd0);

    // Reset while entries pending, asserted in a cycle with core_rvalid high
    set_mode(1'b1, 1, 20, 0);
    c0 = cyc;
    send(32'h31, c0 + 21, 1, 0);
    send(32'h32, c0 + 42, 1, 0);
    send(32'h33, c0 + 63, 1, 0);
    while (cyc < c0 + 21) tick();
    chk("pre_rst_rvalid", 64'(bus.core_rvalid_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(bus.core_rvalid_o), 64'd0);
    chk("mid_rst_rdata", 64'(bus.core_rdata_o), 64'd0);
    chk("mid_rst_full", 64'(bus.full_o), 64'd0);
    chk("mid_rst_ovf", 64'(bus.overflow_o), 64'd0);
    exp_q.delete();
    tick();
    tick();
    #1 rst_n = 1'b1;
    lfsr_m = 32'h1;
    repeat (30) tick();
    set_mode(1'b1, 0, 0, 0);
    c0 = cyc;
    send(32'h77, c0 + 1, 1, 0);
    wait_empty(20);

    // RANDOM, max 7: delays isolated so each is measured directly
    set_mode(1'b1, 2, 0, 7);
    for (int i = 0; i < 1000; i++) begin
`ifdef RVALID_STALL_LFSR_EN
      dly = int'(lfsr_m % 32'd8);
`else
      dly = 7;
`endif
      c0 = cyc;
      send($urandom, c0 + 1 + dly, 1, 1);
      wait_empty(30);
    end
    nhit = 0;
    for (int k = 0; k < 8; k++) nhit += int'(hits[k]);
`ifdef RVALID_STALL_LFSR_EN
    chk("rnd_all_hit", 64'(nhit), 64'd8);
`else
    chk("rnd_only_7", 64'(hits[7]), 64'd1);
    chk("rnd_distinct", 64'(nhit), 64'd1);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
